sram_mem_stage: RTL

Memory-stage controller of the ARM pipeline, directly downstream of the execute-stage ALU.
- Takes the ALU result as a byte address, plus the store value, for LDR/STR instructions.
- Performs each 32-bit access as two 16-bit phases on an external asynchronous SRAM.
- Drops `ready` low for the whole access so the hazard/freeze logic stalls every earlier stage.

---
 rtl/arm_mem_pkg.sv | 27 ++
 rtl/mem_wait_counter.sv | 28 ++
 rtl/sram_mem_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM memory stage and its SRAM interface.
package arm_mem_pkg;

    // External asynchronous SRAM geometry (half-word addressed, 16-bit data).
    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;

    // Width of the per-phase wait counter; WAIT_CYCLES must fit in it (1..15).
    localparam int unsigned CNT_W = 4;

    // First data-memory byte address seen by the pipeline.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0400;

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh,
        StDone
    } mem_state_t;

    // Half-word SRAM address for a word index; upper selects bits [31:16].
    function automatic logic [SRAM_AW-1:0] half_addr(input logic [SRAM_AW-2:0] word,
                                                     input logic upper);
        return {word, upper};
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times how long each SRAM phase is held.
// done_o is high once the count has reached zero.
module mem_wait_counter
    import arm_mem_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;

    // Load on request, otherwise count down and stop at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/sram_mem_stage.sv
// Memory-stage controller: performs each 32-bit LDR/STR as two 16-bit phases on an
// external asynchronous SRAM and holds ready low while the access is in flight.
// Optional feature: define SRAM_ADDR_CHECK_EN to reject out-of-range addresses
// (they complete in one cycle with no SRAM activity; a rejected load returns 0).
module sram_mem_stage
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 1   // legal range 1..15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in
);

    // Counter value that makes a phase last exactly WAIT_CYCLES cycles.
    localparam logic [CNT_W-1:0] PhaseLoad = CNT_W'(WAIT_CYCLES - 1);

    mem_state_t         state_q, state_d;
    logic               op_write_q;
    logic [SRAM_AW-2:0] word_q;       // latched offset[18:2]
    logic [31:0]        wdata_q;
    logic [SRAM_DW-1:0] rd_low_q;     // low half of a load, parked until the high half

    logic               req;
    logic               req_write;
    logic               req_bad;
    logic [31:0]        req_offset;
    logic               phase_done;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               unused_offset;

    assign req        = rd_en | wr_en;
    assign req_write  = wr_en;             // write wins when both enables are high
    assign req_offset = address - BASE_ADDR;

`ifdef SRAM_ADDR_CHECK_EN
    assign req_bad = (address < BASE_ADDR) || (req_offset[31:19] != '0);
`else
    assign req_bad = 1'b0;
`endif

    // Byte-lane bits and high offset bits do not select SRAM words.
    assign unused_offset = ^{req_offset[31:19], req_offset[1:0]};

    // Phase timer restarts on every state change.
    assign cnt_load     = (state_d != state_q);
    assign cnt_load_val = ((state_d == StLow) || (state_d == StHigh)) ? PhaseLoad : '0;

    mem_wait_counter u_wait_counter (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .done_o     (phase_done)
    );

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = req_bad ? StDone : StLow;
                end
            end
            StLow: begin
                if (phase_done) begin
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (phase_done) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Stall the pipeline from the request cycle until DONE.
    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            StIdle:  ready = ~req;
            StDone:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // FSM state, operand latches, registered pad outputs and load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_write_q  <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            rd_low_q    <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_dq_out <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        op_write_q <= req_write;
                        word_q     <= req_offset[18:2];
                        wdata_q    <= write_data;
                        if (req_bad) begin
                            // Rejected access: no strobe, loads return zero.
                            if (!req_write) begin
                                read_data <= '0;
                            end
                        end else begin
                            sram_addr  <= half_addr(req_offset[18:2], 1'b0);
                            sram_we_n  <= ~req_write;
                            sram_dq_oe <= req_write;
                            if (req_write) begin
                                sram_dq_out <= write_data[15:0];
                            end
                        end
                    end
                end
                StLow: begin
                    if (phase_done) begin
                        sram_addr <= half_addr(word_q, 1'b1);
                        if (op_write_q) begin
                            sram_dq_out <= wdata_q[31:16];
                        end else begin
                            rd_low_q <= sram_dq_in;
                        end
                    end
                end
                StHigh: begin
                    if (phase_done) begin
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        // read_data only changes once the whole word is in hand.
                        if (!op_write_q) begin
                            read_data <= {sram_dq_in, rd_low_q};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
